// File: rtl/graph_pkg.sv
// Shared constants, FSM state type and Y saturation helper for the graph calculator.
package graph_pkg;

  localparam int NCOEF    = 5;
  localparam int COEF_W   = 8;
  localparam int X_MIN    = -400;
  localparam int NPOINTS  = 800;
  localparam int Y_W      = 12;
  localparam int Y_LIM    = 240;
  localparam int SCALE_SH = 0;
  localparam int ACC_W    = 48;
  localparam int X_W      = 11;
  localparam int ADDR_W   = 10;
  localparam int SEL_W    = 3;

  localparam logic signed [COEF_W-1:0] COEF_MAX = {1'b0, {(COEF_W-1){1'b1}}};
  localparam logic signed [COEF_W-1:0] COEF_MIN = {1'b1, {(COEF_W-1){1'b0}}};

  localparam logic signed [ACC_W-1:0] Y_HI_ACC   = ACC_W'(2**(Y_W-1)-1);
  localparam logic signed [ACC_W-1:0] Y_LO_ACC   = -Y_HI_ACC - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] Y_LIM_ACC  = ACC_W'(Y_LIM);
  localparam logic signed [ACC_W-1:0] Y_NLIM_ACC = -Y_LIM_ACC;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMac,
    StWrite,
    StDone
  } state_e;

  function automatic logic signed [Y_W-1:0] sat_y(input logic signed [ACC_W-1:0] v);
    if (v > Y_HI_ACC) begin
      sat_y = Y_W'(Y_HI_ACC);
    end else if (v < Y_LO_ACC) begin
      sat_y = Y_W'(Y_LO_ACC);
    end else begin
      sat_y = Y_W'(v);
    end
  endfunction

endpackage

// File: rtl/horner_mac.sv
// One Horner step per enabled cycle: acc <= acc*x + c, 48-bit signed accumulator.
module horner_mac
  import graph_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_load,
  input  logic signed [ACC_W-1:0]  i_load_val,
  input  logic                     i_en,
  input  logic signed [X_W-1:0]    i_x,
  input  logic signed [COEF_W-1:0] i_c,
  output logic signed [ACC_W-1:0]  o_acc_next
);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_prod;

  assign w_prod     = r_acc * ACC_W'(i_x);
  // Exposed combinationally so the caller can register the final sample in the same edge.
  assign o_acc_next = w_prod + ACC_W'(i_c);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= i_load_val;
    end else if (i_en) begin
      r_acc <= o_acc_next;
    end
  end

endmodule

// File: rtl/poly_plot_sequencer.sv
// Coefficient editor and plot sequencer: edits five coefficients from button pulses and
// writes one saturated Horner-evaluated Y sample per screen column into the plot RAM.
module poly_plot_sequencer
  import graph_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_btn_sign,
  input  logic                      i_btn_prev,
  input  logic                      i_btn_next,
  input  logic                      i_btn_inc,
  input  logic                      i_btn_dec,
  input  logic                      i_btn_plot,
  output logic [SEL_W-1:0]          o_sel_idx,
  output logic [NCOEF*COEF_W-1:0]   o_coef_bus,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_wr_en,
  output logic [ADDR_W-1:0]         o_wr_addr,
  output logic signed [Y_W-1:0]     o_wr_data,
  output logic                      o_wr_inrange
);

  state_e                    r_state, w_state_d;
  logic signed [COEF_W-1:0]  r_coef [NCOEF];
  logic [SEL_W-1:0]          r_sel;
  logic [ADDR_W-1:0]         r_col;
  logic [1:0]                r_k;
  logic signed [X_W-1:0]     r_x;
  logic                      r_busy, r_done, r_wr_en, r_wr_inrange;
  logic [ADDR_W-1:0]         r_wr_addr;
  logic signed [Y_W-1:0]     r_wr_data;

  logic signed [COEF_W-1:0]  w_sel_coef, w_neg_coef;
  logic signed [ACC_W-1:0]   w_acc_next, w_r;
  logic                      w_last_mac, w_inrange;

  assign w_sel_coef = r_coef[r_sel];
  // Negating the minimum would overflow; it maps to the maximum instead.
  assign w_neg_coef = (w_sel_coef == COEF_MIN) ? COEF_MAX : -w_sel_coef;
  assign w_last_mac = (r_state == StMac) && (r_k == 2'd0);
  assign w_r        = w_acc_next >>> SCALE_SH;
  assign w_inrange  = (w_r >= Y_NLIM_ACC) && (w_r <= Y_LIM_ACC);

  horner_mac u_mac (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (r_state == StLoad),
    .i_load_val (ACC_W'(r_coef[NCOEF-1])),
    .i_en       (r_state == StMac),
    .i_x        (r_x),
    .i_c        (r_coef[r_k]),
    .o_acc_next (w_acc_next)
  );

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (i_btn_plot) w_state_d = StLoad;
      StLoad:  w_state_d = StMac;
      StMac:   if (r_k == 2'd0) w_state_d = StWrite;
      StWrite: w_state_d = (r_col == ADDR_W'(NPOINTS-1)) ? StDone : StLoad;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_sel        <= '0;
      r_col        <= '0;
      r_k          <= '0;
      r_x          <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_inrange <= 1'b0;
      for (int i = 0; i < NCOEF; i++) r_coef[i] <= '0;
    end else begin
      r_state <= w_state_d;
      r_busy  <= (w_state_d != StIdle) && (w_state_d != StDone);
      r_done  <= (w_state_d == StDone);
      r_wr_en <= w_last_mac;
      if (w_last_mac) begin
        r_wr_addr    <= r_col;
        r_wr_data    <= sat_y(w_r);
        r_wr_inrange <= w_inrange;
      end
      case (r_state)
        StIdle: begin
          if (i_btn_plot) begin
            r_col <= '0;
          end else if (i_btn_sign) begin
            r_coef[r_sel] <= w_neg_coef;
          end else if (i_btn_inc) begin
            if (w_sel_coef != COEF_MAX) r_coef[r_sel] <= w_sel_coef + COEF_W'(1);
          end else if (i_btn_dec) begin
            if (w_sel_coef != COEF_MIN) r_coef[r_sel] <= w_sel_coef - COEF_W'(1);
          end else if (i_btn_next) begin
            if (r_sel != SEL_W'(NCOEF-1)) r_sel <= r_sel + SEL_W'(1);
          end else if (i_btn_prev) begin
            if (r_sel != '0) r_sel <= r_sel - SEL_W'(1);
          end
        end
        StLoad: begin
          r_x <= X_W'(X_MIN) + $signed({1'b0, r_col});
          r_k <= 2'd3;
        end
        StMac:   r_k <= r_k - 2'd1;
        StWrite: r_col <= r_col + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    o_coef_bus = '0;
    for (int i = 0; i < NCOEF; i++) o_coef_bus[i*COEF_W +: COEF_W] = r_coef[i];
  end

  assign o_sel_idx    = r_sel;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_wr_inrange = r_wr_inrange;

endmodule

// File: tb/tb_poly_plot_sequencer.sv
// Scoreboard bench: stimulus pushes expected writes/done pulses, a negedge monitor checks them.
module tb_poly_plot_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  btn = '0;  // {plot, dec, inc, next, prev, sign}
  logic [2:0]  sel_idx;
  logic [39:0] coef_bus;
  logic        busy, done, wr_en, wr_inrange;
  logic [9:0]  wr_addr;
  logic [11:0] wr_data;

  localparam logic [5:0] B_SIGN = 6'b000001;
  localparam logic [5:0] B_PREV = 6'b000010;
  localparam logic [5:0] B_NEXT = 6'b000100;
  localparam logic [5:0] B_INC  = 6'b001000;
  localparam logic [5:0] B_DEC  = 6'b010000;
  localparam logic [5:0] B_PLOT = 6'b100000;

  poly_plot_sequencer dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_btn_sign   (btn[0]),
    .i_btn_prev   (btn[1]),
    .i_btn_next   (btn[2]),
    .i_btn_inc    (btn[3]),
    .i_btn_dec    (btn[4]),
    .i_btn_plot   (btn[5]),
    .o_sel_idx    (sel_idx),
    .o_coef_bus   (coef_bus),
    .o_busy       (busy),
    .o_done       (done),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_wr_inrange (wr_inrange)
  );

  always #20 clk = ~clk;

  typedef struct {
    int cyc;
    int addr;
    int data;
    bit inr;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  writes = 0;
  int  obs_data [800];
  bit  obs_inr  [800];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every write strobe and done pulse against the scoreboard queues.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_t e;
      writes++;
      checks++;
      obs_data[wr_addr] = int'($signed(wr_data));
      obs_inr[wr_addr]  = wr_inrange;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr %0d data %0d cycle %0d", wr_addr,
                 $signed(wr_data), cyc);
      end else begin
        e = wq.pop_front();
        if (e.cyc != cyc || e.addr != int'(wr_addr) || e.data != int'($signed(wr_data)) ||
            e.inr != wr_inrange) begin
          errors++;
          $display("FAIL write actual cyc %0d addr %0d data %0d inr %0d expected cyc %0d addr %0d data %0d inr %0d",
                   cyc, wr_addr, $signed(wr_data), wr_inrange, e.cyc, e.addr, e.data, e.inr);
        end
      end
    end
    if (done) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done actual cycle %0d expected none", cyc);
      end else begin
        int ed;
        ed = dq.pop_front();
        if (ed != cyc) begin
          errors++;
          $display("FAIL done_cycle actual %0d expected %0d", cyc, ed);
        end
      end
    end
  end

  function automatic int sat12(input longint y);
    if (y > 2047) return 2047;
    if (y < -2048) return -2048;
    return int'(y);
  endfunction

  // Direct power-sum reference for the polynomial at one column.
  task automatic push_plot(input int t, input longint c0, input longint c1, input longint c2,
                           input longint c3, input longint c4, input int nwr, input bit with_done);
    for (int n = 0; n < nwr; n++) begin
      longint x, y;
      wr_t e;
      x = -400 + n;
      y = c0 + c1 * x + c2 * x * x + c3 * x * x * x + c4 * x * x * x * x;
      e.cyc  = t + 6 + 6 * n;
      e.addr = n;
      e.data = sat12(y);
      e.inr  = (y >= -240) && (y <= 240);
      wq.push_back(e);
    end
    if (with_done) dq.push_back(t + 4801);
  endtask

  // Called #1 after a posedge; leaves at #1 after the next posedge.
  task automatic press(input logic [5:0] b, input int times);
    for (int i = 0; i < times; i++) begin
      btn = b;
      @(posedge clk);
      #1;
      btn = '0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_plot(input longint c0, input longint c2, input int nwr, input bit wd);
    int t;
    t = cyc;
    writes = 0;
    push_plot(t, c0, 0, c2, 0, 0, nwr, wd);
    chk("busy_before_plot", busy, 0);
    btn = B_PLOT;
    @(posedge clk);
    #1;
    btn = '0;
    chk("busy_at_T+1", busy, 1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((wq.size() != 0 || dq.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("scoreboard_drained", longint'(wq.size() + dq.size()), 0);
  endtask

  initial begin
    int n;
    idle(3);
    reset = 1'b0;
    chk("rst_coef_bus", coef_bus, 0);
    chk("rst_sel", sel_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_inrange", wr_inrange, 0);
    idle(10);
    chk("idle_coef_bus", coef_bus, 0);
    chk("idle_busy", busy, 0);

    // Editing
    press(B_NEXT, 2);
    press(B_INC, 3);
    press(B_SIGN, 1);
    chk("c2_minus3", coef_bus, 40'h00_00_FD_00_00);
    chk("sel_2", sel_idx, 2);
    press(B_NEXT, 5);
    chk("next_holds_4", sel_idx, 4);
    press(B_PREV, 6);
    chk("prev_holds_0", sel_idx, 0);
    press(B_INC | B_DEC | B_NEXT, 1);
    chk("prio_inc_coef", coef_bus, 40'h00_00_FD_00_01);
    chk("prio_inc_sel", sel_idx, 0);
    press(B_SIGN | B_INC, 1);
    chk("prio_sign_coef", coef_bus, 40'h00_00_FD_00_FF);
    press(B_INC, 1);
    press(B_NEXT, 2);
    press(B_INC, 4);
    chk("c2_one", coef_bus, 40'h00_00_01_00_00);

    // Plot y = x^2, with ignored buttons mid-plot
    start_plot(0, 1, 800, 1'b1);
    idle(20);
    press(B_INC, 1);
    idle(80);
    press(B_SIGN, 1);
    idle(80);
    press(B_NEXT, 1);
    idle(80);
    press(B_PLOT, 1);
    drain(6000);
    idle(2);
    chk("plot1_writes", writes, 800);
    chk("plot1_coef_stable", coef_bus, 40'h00_00_01_00_00);
    chk("plot1_sel_stable", sel_idx, 2);
    chk("plot1_busy_end", busy, 0);
    chk("addr0_data", obs_data[0], 2047);
    chk("addr0_inr", obs_inr[0], 0);
    chk("addr400_data", obs_data[400], 0);
    chk("addr400_inr", obs_inr[400], 1);
    chk("addr415_data", obs_data[415], 225);
    chk("addr415_inr", obs_inr[415], 1);
    chk("addr416_data", obs_data[416], 256);
    chk("addr416_inr", obs_inr[416], 0);

    // Reset mid-plot at column 100
    start_plot(0, 1, 101, 1'b0);
    n = 0;
    while (!(wr_en && wr_addr == 10'd100) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_addr100", longint'(n < 1000), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_wr_en", wr_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_coefs", coef_bus, 0);
    chk("abort_writes", writes, 101);
    idle(4800);
    chk("abort_no_more_writes", writes, 101);
    drain(10);

    // Coefficient saturation on c0
    press(B_INC, 130);
    chk("c0_sat_max", coef_bus, 40'h7F);
    press(B_SIGN, 1);
    chk("c0_neg127", coef_bus, 40'h81);
    press(B_DEC, 5);
    chk("c0_sat_min", coef_bus, 40'h80);
    press(B_SIGN, 1);
    chk("c0_sign_min", coef_bus, 40'h7F);
    press(B_SIGN, 1);
    press(B_INC, 122);
    chk("c0_minus5", coef_bus, 40'hFB);

    start_plot(-5, 0, 800, 1'b1);
    drain(6000);
    idle(2);
    chk("plot3_writes", writes, 800);
    chk("plot3_addr0", obs_data[0], -5);
    chk("plot3_addr799", obs_data[799], -5);
    chk("plot3_inr799", obs_inr[799], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog actual timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
